// File: rtl/rw_access_ctrl.sv
// Arbiter for one shared port between a write and a read requester.
// Under contention each side gets at most BURST_MAX consecutive grant cycles.
module rw_access_ctrl #(
    parameter int BURST_MAX = 4,
    parameter int LIMIT     = 14
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_req,
    input  logic       rd_req,
    input  logic       clr_cnt,
    output logic       wr_en,
    output logic       rd_en,
    output logic       valid,
    output logic [7:0] conflict_cnt,
    output logic       limit_hit
);

    localparam logic [3:0] BURST_MAX_C = 4'(BURST_MAX);
    localparam logic [7:0] LIMIT_C     = 8'(LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic [3:0] run_cnt_q, run_cnt_d;
    logic [7:0] conflict_cnt_q, conflict_cnt_d;
    logic       wr_en_q, rd_en_q, valid_q;

    // Next-state selection; on contention from IDLE the side not served last wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (wr_req && rd_req) begin
                    state_d = last_grant_q ? WRITE : READ;
                end else if (wr_req) begin
                    state_d = WRITE;
                end else if (rd_req) begin
                    state_d = READ;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (wr_req && (!rd_req || (run_cnt_q < BURST_MAX_C))) begin
                    state_d = WRITE;
                end else if (rd_req) begin
                    state_d = READ;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (rd_req && (!wr_req || (run_cnt_q < BURST_MAX_C))) begin
                    state_d = READ;
                end else if (wr_req) begin
                    state_d = WRITE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Burst length and last-served side bookkeeping, driven by the upcoming state.
    always_comb begin
        run_cnt_d    = run_cnt_q;
        last_grant_d = last_grant_q;
        if (state_d == IDLE) begin
            run_cnt_d = 4'd0;
        end else if (state_d != state_q) begin
            run_cnt_d    = 4'd1;
            last_grant_d = (state_d == READ);
        end else if (run_cnt_q != 4'd15) begin
            run_cnt_d = run_cnt_q + 4'd1;
        end else begin
            run_cnt_d = run_cnt_q;
        end
    end

    // Saturating conflict counter; clear wins over a simultaneous conflict.
    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (clr_cnt) begin
            conflict_cnt_d = 8'd0;
        end else if (wr_req && rd_req && (conflict_cnt_q != 8'd255)) begin
            conflict_cnt_d = conflict_cnt_q + 8'd1;
        end else begin
            conflict_cnt_d = conflict_cnt_q;
        end
    end

    // State and registered strobes; strobes decode the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            last_grant_q   <= 1'b1;
            run_cnt_q      <= 4'd0;
            conflict_cnt_q <= 8'd0;
            wr_en_q        <= 1'b0;
            rd_en_q        <= 1'b0;
            valid_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            run_cnt_q      <= run_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
            wr_en_q        <= (state_d == WRITE);
            rd_en_q        <= (state_d == READ);
            valid_q        <= (state_d != IDLE);
        end
    end

    assign wr_en        = wr_en_q;
    assign rd_en        = rd_en_q;
    assign valid        = valid_q;
    assign conflict_cnt = conflict_cnt_q;
    assign limit_hit    = (conflict_cnt_q >= LIMIT_C);

endmodule

// File: tb/tb_rw_access_ctrl.sv
// Self-checking bench for rw_access_ctrl: directed scenarios plus random traffic
// compared against a winner-selection model of the arbitration rules.
module tb_rw_access_ctrl;

    localparam int BURST_MAX = 4;
    localparam int LIMIT     = 14;

    logic       clk;
    logic       rst_n;
    logic       wr_req;
    logic       rd_req;
    logic       clr_cnt;
    logic       wr_en;
    logic       rd_en;
    logic       valid;
    logic [7:0] conflict_cnt;
    logic       limit_hit;

    int n_checks;
    int n_errors;

    // Model: owner 0 = nobody, 1 = writer, 2 = reader.
    int m_owner;
    int m_streak;
    bit m_last_read;
    int m_conf;

    rw_access_ctrl #(.BURST_MAX(BURST_MAX), .LIMIT(LIMIT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .clr_cnt      (clr_cnt),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .valid        (valid),
        .conflict_cnt (conflict_cnt),
        .limit_hit    (limit_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner     = 0;
        m_streak    = 0;
        m_last_read = 1'b1;
        m_conf      = 0;
    endtask

    // Decide who owns the port next cycle from the current owner and who is asking.
    task automatic model_step(input bit wr, input bit rd, input bit clr);
        int nxt;
        if (wr && rd) begin
            if (m_owner == 0)              nxt = m_last_read ? 1 : 2;
            else if (m_streak < BURST_MAX) nxt = m_owner;
            else                           nxt = 3 - m_owner;
        end else if (wr) begin
            nxt = 1;
        end else if (rd) begin
            nxt = 2;
        end else begin
            nxt = 0;
        end
        if (nxt == 0) begin
            m_streak = 0;
        end else if (nxt == m_owner) begin
            m_streak = m_streak + 1;
        end else begin
            m_streak    = 1;
            m_last_read = (nxt == 2);
        end
        m_owner = nxt;
        if (clr)           m_conf = 0;
        else if (wr && rd) m_conf = (m_conf < 255) ? m_conf + 1 : 255;
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, "_wr_en"}, 32'(wr_en), 32'(m_owner == 1));
        check_eq({tag, "_rd_en"}, 32'(rd_en), 32'(m_owner == 2));
        check_eq({tag, "_valid"}, 32'(valid), 32'(m_owner != 0));
        check_eq({tag, "_cnt"}, 32'(conflict_cnt), 32'(m_conf));
        check_eq({tag, "_limit"}, 32'(limit_hit), 32'(m_conf >= LIMIT));
        check_eq({tag, "_excl"}, 32'(wr_en & rd_en), 32'd0);
    endtask

    task automatic step(input bit wr, input bit rd, input bit clr, input string tag);
        wr_req  = wr;
        rd_req  = rd;
        clr_cnt = clr;
        @(posedge clk);
        model_step(wr, rd, clr);
        #1;
        check_model(tag);
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_model("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        wr_req   = 1'b0;
        rd_req   = 1'b0;
        clr_cnt  = 1'b0;
        model_reset();

        // Lone writer keeps the port; first grant one cycle after first sample.
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 1'b0, "solo_wr");
            check_eq("solo_wr_grant", 32'(wr_en), 32'd1);
        end
        step(1'b0, 1'b0, 1'b0, "solo_wr_end");

        // Contention from IDLE: 4 writes, 4 reads, 4 writes, no gap.
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, 1'b0, "alt");
            check_eq("alt_pattern_wr", 32'(wr_en), 32'(((i / BURST_MAX) % 2) == 0));
            check_eq("alt_pattern_valid", 32'(valid), 32'd1);
        end
        check_eq("alt_cnt12", 32'(conflict_cnt), 32'd12);

        // limit_hit rises exactly when the count reaches LIMIT.
        for (int i = 12; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, "lim");
            check_eq("lim_edge", 32'(limit_hit), 32'((i + 1) >= LIMIT));
        end

        // Saturation at 255, then clear with requests still high.
        for (int i = 0; i < 280; i++) step(1'b1, 1'b1, 1'b0, "sat");
        check_eq("sat_255", 32'(conflict_cnt), 32'd255);
        step(1'b1, 1'b1, 1'b1, "clr");
        check_eq("clr_zero", 32'(conflict_cnt), 32'd0);
        check_eq("clr_limit", 32'(limit_hit), 32'd0);

        // Asynchronous reset in the middle of a write grant.
        apply_reset();
        step(1'b1, 1'b0, 1'b0, "arst_pre");
        step(1'b1, 1'b0, 1'b0, "arst_pre");
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("arst_wr_en", 32'(wr_en), 32'd0);
        check_eq("arst_valid", 32'(valid), 32'd0);
        wr_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b0, "arst_post");
        check_eq("arst_post_rd", 32'(rd_en), 32'd1);

        // Writer drops while reader waits, then both drop.
        apply_reset();
        step(1'b1, 1'b0, 1'b0, "drop");
        step(1'b1, 1'b0, 1'b0, "drop");
        step(1'b0, 1'b1, 1'b0, "drop_sw");
        check_eq("drop_sw_rd", 32'(rd_en), 32'd1);
        check_eq("drop_sw_valid", 32'(valid), 32'd1);
        step(1'b0, 1'b0, 1'b0, "drop_idle");
        check_eq("drop_idle_valid", 32'(valid), 32'd0);

        // Random traffic with occasional clears.
        apply_reset();
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 65,
                 $urandom_range(0, 99) < 3, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rw_access_ctrl.md
RW_ACCESS_CTRL -- requirements
Module: rw_access_ctrl

Interface
REQ-001 Parameter BURST_MAX, default 4: maximum consecutive grant cycles to one side while the other side is requesting; legal range 1..15.
REQ-002 Parameter LIMIT, default 14: conflict count at which limit_hit asserts; legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 wr_req  input  1  write requester asks for the shared port; held high until served.
REQ-006 rd_req  input  1  read requester asks for the shared port; held high until served.
REQ-007 clr_cnt  input  1  synchronous clear of conflict_cnt.
REQ-008 wr_en  output  1  write grant / write strobe to shared resource; registered.
REQ-009 rd_en  output  1  read grant / read strobe to shared resource; registered.
REQ-010 valid  output  1  port active this cycle, equal to wr_en OR rd_en; registered.
REQ-011 conflict_cnt  output  8  count of cycles with wr_req and rd_req both high; registered.
REQ-012 limit_hit  output  1  conflict_cnt >= LIMIT; combinational from conflict_cnt.

Function
REQ-013 FSM states IDLE, WRITE, READ; wr_en = (state==WRITE), rd_en = (state==READ); wr_en and rd_en are never both 1 in any cycle.
REQ-014 Latency: a request sampled at posedge k from IDLE produces the grant in the cycle after posedge k (one-cycle latency).
REQ-015 IDLE: wr_req only -> WRITE; rd_req only -> READ; both -> side opposite last_grant; neither -> IDLE.
REQ-016 last_grant is a 1-bit register updated on every entry into WRITE (0) or READ (1); reset value 1, so the first simultaneous request after reset goes to WRITE.
REQ-017 run_cnt (4-bit) counts consecutive cycles in the current grant state; set to 1 on entry, incremented while staying, saturating at 15.
REQ-018 WRITE: stay if wr_req and (not rd_req or run_cnt < BURST_MAX); else READ if rd_req; else IDLE.
REQ-019 READ: symmetric to REQ-018 with roles of wr_req/rd_req swapped.
REQ-020 Direct WRITE<->READ switch has no idle gap; valid stays 1 across the switch.
REQ-021 With only one side requesting, that side holds the port indefinitely regardless of BURST_MAX.
REQ-022 conflict_cnt increments by 1 on each posedge where wr_req and rd_req are both 1, saturating at 255 (no wrap).
REQ-023 clr_cnt has priority over increment: clr_cnt=1 at posedge sets conflict_cnt to 0 even if a conflict occurs that cycle.
REQ-024 Request dropped while granted: grant deasserts in the following cycle per REQ-018/019; requester must not expect a grant after dropping.

Reset
REQ-025 rst_n low asynchronously forces state=IDLE, wr_en=0, rd_en=0, valid=0, run_cnt=0, last_grant=1, conflict_cnt=0; limit_hit follows to 0.
REQ-026 Reset asserted mid-grant removes wr_en/rd_en immediately (no wait for clk); after rst_n release, first grant is no earlier than one cycle after the first sampled request.

Verification
REQ-027 Reset then wr_req=1 alone for 6 cycles -> wr_en=1 from cycle 2 through cycle 7, rd_en=0 throughout, conflict_cnt=0.
REQ-028 wr_req=rd_req=1 from IDLE after reset, held 12 cycles, BURST_MAX=4 -> grants alternate W,W,W,W,R,R,R,R,W,W,W,W with no gap; conflict_cnt=12.
REQ-029 wr_req=rd_req=1 held 20 cycles, LIMIT=14 -> limit_hit rises the cycle conflict_cnt reaches 14; never wr_en=rd_en=1 (bench assertion every cycle).
REQ-030 Hold both requests 300 cycles -> conflict_cnt saturates at 255; pulse clr_cnt with requests still high -> conflict_cnt=0 next cycle, limit_hit=0.
REQ-031 During WRITE grant drive rst_n=0 between clock edges -> wr_en, valid fall without a clock edge; after release with rd_req=1 -> rd_en=1 one cycle after first sample.
REQ-032 In WRITE, drop wr_req while rd_req=1 -> rd_en=1 next cycle, valid continuous; drop both -> IDLE, valid=0 next cycle.
